game_seq: RTL and testbench

GAME_SEQ -- requirements
Module: game_seq

---
 rtl/game_pkg.sv | 17 +
 rtl/bcd_inc4.sv | 27 ++
 rtl/game_seq.sv | 166 ++++++++++++++++
 tb/tb_game_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state codes, BCD score type
// and the score saturation value.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef logic [15:0] bcd16_t;

  localparam bcd16_t SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_inc4.sv
// Combinational four-digit BCD increment with carry ripple; holds at 9999.
module bcd_inc4
  import game_pkg::*;
(
  input  logic [15:0] din,
  output logic [15:0] dout
);

  always_comb begin
    logic carry;
    dout  = din;
    carry = 1'b1;
    if (din != SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (din[4*i +: 4] >= 4'd9) begin
            dout[4*i +: 4] = 4'd0;
          end else begin
            dout[4*i +: 4] = din[4*i +: 4] + 4'd1;
            carry          = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_seq.sv
// Game sequencer: IDLE/PLAY/HIT/PAUSE/OVER control, BCD scoring and lives.
// Optional high-score register enabled by defining GAME_SEQ_HISCORE_EN.
module game_seq
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int SCORE_TICKS = 4,
  parameter int HIT_TICKS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        coll,
  output logic        move_en,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        blank,
  output logic        game_over
`ifdef GAME_SEQ_HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  localparam logic [3:0] SCORE_LAST = 4'(SCORE_TICKS - 1);
  localparam logic [3:0] HIT_LAST   = 4'(HIT_TICKS - 1);
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_t     state_q, state_d;
  logic       coll_q;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  bcd16_t     score_q, score_d, score_inc;
  logic [1:0] lives_q, lives_d;
  logic       blank_q, blank_d;
  logic       move_en_q, move_en_d;
  logic       game_over_q, game_over_d;
  logic       coll_edge;

  assign coll_edge = coll & ~coll_q;

  bcd_inc4 u_inc (
    .din  (score_q),
    .dout (score_inc)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      coll_q      <= 1'b0;
      tick_cnt_q  <= '0;
      hit_cnt_q   <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_LOAD;
      blank_q     <= 1'b0;
      move_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coll_q      <= coll;
      tick_cnt_q  <= tick_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      blank_q     <= blank_d;
      move_en_q   <= move_en_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    score_d    = score_q;
    lives_d    = lives_q;
    blank_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          lives_d    = LIVES_LOAD;
          tick_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        // A collision edge pre-empts scoring and pause in the same cycle.
        if (coll_edge) begin
          if (lives_q > 2'd1) begin
            lives_d   = lives_q - 2'd1;
            state_d   = ST_HIT;
            hit_cnt_d = '0;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end else begin
          if (tick) begin
            if (tick_cnt_q == SCORE_LAST) begin
              tick_cnt_d = '0;
              score_d    = score_inc;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
          if (start) state_d = ST_PAUSE;
        end
      end
      ST_HIT: begin
        blank_d = blank_q;
        if (tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            blank_d   = 1'b0;
            state_d   = ST_PLAY;
          end else begin
            hit_cnt_d = hit_cnt_q + 4'd1;
            blank_d   = ~blank_q;
          end
        end
      end
      ST_PAUSE: begin
        if (start) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the upcoming state
  always_comb begin
    move_en_d   = (state_d == ST_PLAY) || (state_d == ST_HIT);
    game_over_d = (state_d == ST_OVER);
  end

  assign state     = state_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign blank     = blank_q;
  assign move_en   = move_en_q;
  assign game_over = game_over_q;

`ifdef GAME_SEQ_HISCORE_EN
  bcd16_t hiscore_q;

  // BCD digits compare correctly as plain unsigned values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore_q <= '0;
    end else if ((state_d == ST_OVER) && (state_q != ST_OVER) &&
                 (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`endif

endmodule

// File: tb/tb_game_seq.sv
// Scoreboard bench for game_seq: directed scenarios followed by random
// stimulus, compared against a behavioural model of the game rules.
module tb_game_seq;

  localparam int LIVES_INIT  = 3;
  localparam int SCORE_TICKS = 4;
  localparam int HIT_TICKS   = 8;

  logic        clk = 1'b0;
  logic        reset, tick, start, coll;
  logic        move_en, blank, game_over;
  logic [2:0]  state;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [15:0] hiscore_w;

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];

  // Model state, kept as plain integers
  int m_state, m_score, m_lives, m_tcnt, m_hcnt, m_hi;
  bit m_blank, m_cprev;

  always #5 clk = ~clk;

`ifdef GAME_SEQ_HISCORE_EN
  game_seq #(.LIVES_INIT(LIVES_INIT), .SCORE_TICKS(SCORE_TICKS), .HIT_TICKS(HIT_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .coll(coll),
    .move_en(move_en), .state(state), .score(score), .lives(lives),
    .blank(blank), .game_over(game_over), .hiscore(hiscore_w)
  );
`else
  game_seq #(.LIVES_INIT(LIVES_INIT), .SCORE_TICKS(SCORE_TICKS), .HIT_TICKS(HIT_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .coll(coll),
    .move_en(move_en), .state(state), .score(score), .lives(lives),
    .blank(blank), .game_over(game_over)
  );
  assign hiscore_w = 16'h0000;
`endif

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [39:0] model_out();
    logic me, go;
    me = (m_state == 1) || (m_state == 2);
    go = (m_state == 4);
    return {me, 3'(m_state), to_bcd(m_score), 2'(m_lives), m_blank, go, to_bcd(m_hi)};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit s, input bit c);
    bit ce;
    if (r) begin
      m_state = 0; m_score = 0; m_lives = LIVES_INIT; m_tcnt = 0; m_hcnt = 0;
      m_blank = 0; m_cprev = 0; m_hi = 0;
      return;
    end
    ce = c && !m_cprev;
    m_cprev = c;
    case (m_state)
      0: if (s) begin
        m_state = 1; m_score = 0; m_lives = LIVES_INIT; m_tcnt = 0;
      end
      1: if (ce) begin
        if (m_lives > 1) begin
          m_lives--; m_state = 2; m_hcnt = 0; m_blank = 0;
        end else begin
          m_lives = 0; m_state = 4;
`ifdef GAME_SEQ_HISCORE_EN
          if (m_score > m_hi) m_hi = m_score;
`endif
        end
      end else begin
        if (t) begin
          m_tcnt++;
          if (m_tcnt == SCORE_TICKS) begin
            m_tcnt = 0;
            m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
          end
        end
        if (s) m_state = 3;
      end
      2: if (t) begin
        m_hcnt++;
        m_blank = !m_blank;
        if (m_hcnt == HIT_TICKS) begin
          m_state = 1; m_blank = 0; m_hcnt = 0;
        end
      end
      3: if (s) m_state = 1;
      4: if (s) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic step(input bit r, input bit t, input bit s, input bit c);
    @(negedge clk);
    reset = r; tick = t; start = s; coll = c;
    model_step(r, t, s, c);
    exp_q.push_back(model_out());
  endtask

  // Pulse a collision from PLAY and ride out the HIT recovery
  task automatic hit_once();
    int guard;
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    guard = 0;
    while (m_state == 2 && guard < 100) begin
      step(0, 1, 0, 0);
      guard++;
    end
  endtask

  task automatic lose_all();
    int guard;
    guard = 0;
    while (m_state != 4 && guard < 10) begin
      hit_once();
      guard++;
    end
  endtask

  // Monitor: outputs are registered, so one expectation per clock edge
  initial begin
    logic [39:0] got, expv;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        got  = {move_en, state, score, lives, blank, game_over, hiscore_w};
        total++;
        if (got !== expv) begin
          bad++;
          $display("FAIL outputs t=%0t got me=%b st=%0d sc=%h lv=%0d bl=%b go=%b hi=%h exp me=%b st=%0d sc=%h lv=%0d bl=%b go=%b hi=%h",
                   $time, got[39], got[38:36], got[35:20], got[19:18], got[17], got[16], got[15:0],
                   expv[39], expv[38:36], expv[35:20], expv[19:18], expv[17], expv[16], expv[15:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; tick = 1'b0; start = 1'b0; coll = 1'b0;
    model_step(1, 0, 0, 0);

    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);                       // IDLE -> PLAY
    repeat (12) step(0, 1, 0, 0);           // score 0003
    repeat (384) step(0, 1, 0, 0);          // score 0099
    repeat (4) step(0, 1, 0, 0);            // score 0100

    repeat (20) step(0, 1, 0, 1);           // one hit despite coll held high
    step(0, 0, 0, 0);

    step(0, 0, 1, 0);                       // PLAY -> PAUSE
    repeat (10) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);                       // PAUSE -> PLAY

    repeat (40000) step(0, 1, 0, 0);        // saturate at 9999
    repeat (4) step(0, 1, 0, 0);

    hit_once();                             // lives down to 1
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);                       // coll wins over tick and start
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);                       // OVER -> IDLE

    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0);
    step(1, 1, 1, 1);                       // reset mid-flash
    step(0, 0, 0, 0);

    step(0, 0, 1, 0);
    repeat (168) step(0, 1, 0, 0);          // score 0042
    lose_all();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (68) step(0, 1, 0, 0);           // score 0017
    lose_all();
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
